// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised IEEE 754 multiplier.
package fp_pkg;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: positive, exponent all-ones, fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] q;
    q = ((64'd1 << exp_w) - 64'd1) << man_w;
    q = q | (64'd1 << (man_w - 32'd1));
    return q;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
interface fp_mul_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  import fp_pkg::*;

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] p;
  fp_flags_t    flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, flags
  );

endinterface

// File: rtl/fp_classify.sv
// Splits an IEEE operand into fields and classifies it.
module fp_classify
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x_i,
  output fp_class_t            cls_o,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W-1:0]     frac_o
);

  always_comb begin
    sign_o = x_i[EXP_W+MAN_W];
    exp_o  = x_i[EXP_W+MAN_W-1:MAN_W];
    frac_o = x_i[MAN_W-1:0];
    cls_o  = NORM;
    if (exp_o == '0) begin
      cls_o = (frac_o == '0) ? ZERO : SUB;
    end else if (&exp_o) begin
      if (frac_o == '0) begin
        cls_o = INF;
      end else begin
        cls_o = frac_o[MAN_W-1] ? QNAN : SNAN;
      end
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE 754 multiplier: RNE rounding, flush-to-zero, exception flags,
// valid/ready at both ends with a global stall.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic           clk,
  input logic           rst,
  fp_mul_pipe_if.slave  io
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned PW = 2 * (MAN_W + 1);
  localparam int unsigned EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS     = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic [W-1:0]         QNAN_V   = W'(fp_qnan(EXP_W, MAN_W));

  logic adv;

  // Operand capture
  logic         v1_q, v1_d;
  logic [W-1:0] a1_q, a1_d, b1_q, b1_d;

  // S1 results
  logic                 v2_q, v2_d, sign2_q, sign2_d;
  fp_class_t            cls_a2_q, cls_a2_d, cls_b2_q, cls_b2_d;
  logic signed [EW-1:0] exp2_q, exp2_d;
  logic [PW-1:0]        prod2_q, prod2_d;

  // S2 results
  logic                 v3_q, v3_d, sign3_q, sign3_d;
  fp_class_t            cls_a3_q, cls_a3_d, cls_b3_q, cls_b3_d;
  logic signed [EW-1:0] exp3_q, exp3_d;
  logic [MAN_W:0]       mant3_q, mant3_d;
  logic                 g3_q, g3_d, r3_q, r3_d, st3_q, st3_d;

  // Output registers
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] p_q, p_d;
  fp_flags_t    flags_q, flags_d;

  fp_class_t            cls_a, cls_b;
  logic                 sa, sb;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic [PW-1:0]        norm;
  logic                 round_up, any_nan, any_snan, any_inf, any_zero;
  logic [MAN_W+1:0]     mant_r;
  logic signed [EW-1:0] exp_f;
  logic [MAN_W-1:0]     frac_f;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x_i(a1_q), .cls_o(cls_a), .sign_o(sa), .exp_o(ea), .frac_o(fa)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x_i(b1_q), .cls_o(cls_b), .sign_o(sb), .exp_o(eb), .frac_o(fb)
  );

  always_comb begin
    adv  = !out_valid_q || io.out_ready;
    v1_d = io.in_valid;
    a1_d = io.a;
    b1_d = io.b;

    // S1: exponent sum and full mantissa product
    v2_d     = v1_q;
    sign2_d  = sa ^ sb;
    cls_a2_d = cls_a;
    cls_b2_d = cls_b;
    exp2_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    prod2_d  = PW'({1'b1, fa}) * PW'({1'b1, fb});

    // S2: product is in [1,4); align so the leading one sits at the MSB
    norm     = prod2_q[PW-1] ? prod2_q : (prod2_q << 1);
    v3_d     = v2_q;
    sign3_d  = sign2_q;
    cls_a3_d = cls_a2_q;
    cls_b3_d = cls_b2_q;
    exp3_d   = prod2_q[PW-1] ? (exp2_q + EXP_ONE) : exp2_q;
    mant3_d  = norm[PW-1 -: MAN_W+1];
    g3_d     = norm[MAN_W];
    r3_d     = norm[MAN_W-1];
    st3_d    = |norm[MAN_W-2:0];

    // S3: RNE, range check, then special operands override everything
    round_up = g3_q & (r3_q | st3_q | mant3_q[0]);
    mant_r   = {1'b0, mant3_q} + (MAN_W+2)'(round_up);
    exp_f    = exp3_q;
    frac_f   = mant_r[MAN_W-1:0];
    if (mant_r[MAN_W+1]) begin
      exp_f  = exp3_q + EXP_ONE;
      frac_f = mant_r[MAN_W:1];
    end
    p_d             = {sign3_q, exp_f[EXP_W-1:0], frac_f};
    flags_d         = '0;
    flags_d.inexact = g3_q | r3_q | st3_q;
    if (exp_f >= EXP_MAX) begin
      p_d              = {sign3_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d.overflow = 1'b1;
      flags_d.inexact  = 1'b1;
    end else if (exp_f <= EXP_ZERO) begin
      p_d               = {sign3_q, {(W-1){1'b0}}};
      flags_d.underflow = 1'b1;
      flags_d.inexact   = 1'b1;
    end

    any_nan  = (cls_a3_q inside {QNAN, SNAN}) || (cls_b3_q inside {QNAN, SNAN});
    any_snan = (cls_a3_q == SNAN) || (cls_b3_q == SNAN);
    any_inf  = (cls_a3_q == INF) || (cls_b3_q == INF);
    any_zero = (cls_a3_q inside {ZERO, SUB}) || (cls_b3_q inside {ZERO, SUB});
    if (any_nan) begin
      p_d             = QNAN_V;
      flags_d         = '0;
      flags_d.invalid = any_snan;
    end else if (any_inf && any_zero) begin
      p_d             = QNAN_V;
      flags_d         = '0;
      flags_d.invalid = 1'b1;
    end else if (any_inf) begin
      p_d     = {sign3_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = '0;
    end else if (any_zero) begin
      p_d     = {sign3_q, {(W-1){1'b0}}};
      flags_d = '0;
    end
    out_valid_d = v3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      v1_q        <= v1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      v2_q        <= v2_d;
      sign2_q     <= sign2_d;
      cls_a2_q    <= cls_a2_d;
      cls_b2_q    <= cls_b2_d;
      exp2_q      <= exp2_d;
      prod2_q     <= prod2_d;
      v3_q        <= v3_d;
      sign3_q     <= sign3_d;
      cls_a3_q    <= cls_a3_d;
      cls_b3_q    <= cls_b3_d;
      exp3_q      <= exp3_d;
      mant3_q     <= mant3_d;
      g3_q        <= g3_d;
      r3_q        <= r3_d;
      st3_q       <= st3_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      flags_q     <= flags_d;
    end
  end

  assign io.in_ready  = adv;
  assign io.out_valid = out_valid_q;
  assign io.p         = p_q;
  assign io.flags     = flags_q;

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, pipelined IEEE 754 multiplier with integrated special-operand resolution, round-to-nearest-even and exception flags. Generalises the single-precision combinational multiplier/special-case path to any exponent/mantissa width. Adds a 3-stage pipeline with valid/ready flow control at both ends. Sits between the operand-issue logic and the FP result writeback in the arithmetic datapath.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MAN_W`, default 23: stored fraction width, without the hidden bit.
- Derived: `W = 1+EXP_W+MAN_W`; `BIAS = 2^(EXP_W-1)-1`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block accepts the pair this cycle.
- `a`, `b`  in  W  operands, IEEE layout {sign, exp, frac}.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `p`  out  W  product.
- `flags`  out  4  {invalid, overflow, underflow, inexact}; valid with `out_valid`.

## Operation
- Classify each operand as zero, subnormal, normal, Inf, qNaN or sNaN.
  - Subnormal inputs are flushed to signed zero.
  - sNaN means exp all-ones, fraction non-zero, fraction MSB 0.
- Result sign is `sa ^ sb` for all non-NaN results, including zero and Inf.
- Special resolution, first match wins:
  - Any NaN operand → canonical qNaN {0, all-ones, 1, 0…} (32-bit: 0x7FC00000). Set invalid if either operand is sNaN.
  - Inf × zero, either order → canonical qNaN, invalid=1.
  - Inf × anything else → signed Inf.
  - Zero × finite → signed zero.
- Finite path:
  - Mantissa product is (1.fa)×(1.fb), width `2*(MAN_W+1)`.
  - Exponent is `ea+eb-BIAS`, held signed in `EXP_W+2` bits.
  - Normalise by at most one left-shift position (product in [1,4)); increment the exponent if the product MSB is set.
  - Round RNE using guard, round and sticky bits. Rounding carry-out renormalises and increments the exponent.
  - inexact=1 whenever any discarded bit is non-zero.
- Overflow: final exponent ≥ all-ones → signed Inf, overflow=1, inexact=1.
- Underflow: final exponent ≤ 0 → signed zero (flush-to-zero, no subnormal output), underflow=1, inexact=1 unless the exact product was zero.

## Timing
- 3 pipeline stages, each with its own valid bit:
  - S1: classify, exponent sum, mantissa multiply.
  - S2: normalise, compute GRS bits.
  - S3: round, apply special override, register outputs.
- Latency: a pair accepted at edge N appears on `p`/`out_valid` after edge N+3 when there is no stall. Throughput is 1 per cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - `adv = !out_valid || out_ready`.
  - `in_ready = adv` (global stall). All stages hold when `adv=0`.
  - `p` and `flags` are stable while `out_valid && !out_ready`.
- Bubbles propagate. A stage with valid=0 never raises `out_valid`.
- Simultaneous accept and emit in the same cycle is allowed. Ordering is strictly FIFO.
- Reset values: all stage valid bits, `out_valid`, `p` and `flags` are 0; `in_ready` is 1 in the first cycle after reset.
- Reset mid-operation: all in-flight results are discarded at the reset edge and nothing is emitted for them.
- `a`/`b` are don't-care when `in_valid=0`. Flags are never sticky; they describe only the current result.

## Structure
- Package `fp_pkg` holds:
  - class enum `fp_class_t` {ZERO, SUB, NORM, INF, QNAN, SNAN};
  - packed struct `fp_flags_t` {invalid, overflow, underflow, inexact};
  - functions `fp_bias(EXP_W)` and `fp_qnan(EXP_W, MAN_W)`.
- One sub-module, `fp_classify`, parametrised on EXP_W/MAN_W. It is instantiated twice in S1 and outputs `fp_class_t` plus the unpacked sign/exp/fraction.
- Stage registers live inline in `fp_mul_pipe`.

## Test plan
- 0x40400000 × 0x40000000, out_ready=1 → 0x40C00000 three cycles later, flags=0000.
- 0x7F800000 × 0x80000000 → 0x7FC00000, invalid=1. Also 0xFF800000 × 0x40000000 → 0xFF800000, flags=0000.
- 0x7F000000 × 0x7F000000 → 0x7F800000, overflow=1, inexact=1. Also 0x00800000 × 0x80800000 → 0x80000000, underflow=1, inexact=1.
- 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1 (RNE). Also 0x7F800001 × 0x3F800000 → 0x7FC00000, invalid=1.
- Stream 6 back-to-back pairs with out_ready low for cycles 4–6:
  - no loss or duplication, results in order;
  - `p` stable during the stall;
  - in_ready mirrors adv.
- Assert rst with 3 results in flight → out_valid=0 the next cycle, none of those results are ever emitted. A new pair issued after reset → correct result at latency 3.
- EXP_W=5, MAN_W=10 (half precision): 0x4200 × 0x4000 → 0x4600. Also 0x7C00 × 0x0000 → 0x7E00, invalid=1.
